// File: rtl/irr_param.sv
`default_nettype none
// ============================================================================
// Module   : irr_param
// Purpose  : Interrupt request register for an 8259-style PIC core.
//            Synchronised IR lines, per-channel edge/level capture, freeze
//            window with held edges, served-bit clear and overrun flags.
// Revision : 1.0  initial release
// ============================================================================
module irr_param #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ir_in,
    input  logic [N_CH-1:0] trig_level,
    input  logic            init,
    input  logic            freeze,
    input  logic [N_CH-1:0] clear_irr,
    input  logic [N_CH-1:0] lost_clr,
    output logic [N_CH-1:0] irr_out,
    output logic            irr_any,
    output logic [N_CH-1:0] lost_req
);

    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] r_ir_prev;
    logic [N_CH-1:0] r_edge_hold;
    logic [N_CH-1:0] r_irr;
    logic [N_CH-1:0] r_lost;
    logic            r_irr_any;

    logic [N_CH-1:0] w_ir_s;
    logic [N_CH-1:0] w_edge_mode;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_arrive;
    logic [N_CH-1:0] w_level_next;
    logic [N_CH-1:0] w_edge_next;
    logic [N_CH-1:0] w_irr_nxt;
    logic [N_CH-1:0] w_hold_nxt;
    logic [N_CH-1:0] w_lost_nxt;
    logic [N_CH-1:0] w_prev_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= ir_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_comb begin
        w_ir_s       = r_sync[SYNC_STAGES-1];
        w_edge_mode  = ~trig_level;
        w_rise       = w_ir_s & ~r_ir_prev & w_edge_mode;
        // A held edge only counts as arriving on the cycle it is released.
        w_arrive     = w_rise | (r_edge_hold & w_edge_mode & {N_CH{~freeze}});
        w_level_next = w_ir_s & ~clear_irr;
        // A rise in the same cycle as a clear is a fresh request and survives.
        w_edge_next  = (r_irr | w_rise | r_edge_hold) & w_ir_s & ~(clear_irr & ~w_rise);

        w_irr_nxt  = '0;
        w_hold_nxt = '0;
        w_lost_nxt = '0;
        w_prev_nxt = w_ir_s;

        if (init) begin
            // All-ones previous sample forces a high line to fall before re-arming.
            w_prev_nxt = '1;
        end else begin
            if (freeze) begin
                w_irr_nxt  = r_irr & ~clear_irr;
                w_hold_nxt = r_edge_hold | w_rise;
            end else begin
                w_irr_nxt  = (trig_level & w_level_next) | (w_edge_mode & w_edge_next);
                w_hold_nxt = '0;
            end
            w_lost_nxt = (r_lost & ~lost_clr) | (w_arrive & r_irr & ~clear_irr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_prev   <= '0;
            r_edge_hold <= '0;
            r_irr       <= '0;
            r_lost      <= '0;
            r_irr_any   <= 1'b0;
        end else begin
            r_ir_prev   <= w_prev_nxt;
            r_edge_hold <= w_hold_nxt;
            r_irr       <= w_irr_nxt;
            r_lost      <= w_lost_nxt;
            r_irr_any   <= |w_irr_nxt;
        end
    end

    assign irr_out  = r_irr;
    assign irr_any  = r_irr_any;
    assign lost_req = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_irr_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_irr_param
// Purpose  : Directed self-checking bench for irr_param (N_CH=8, 2 sync stages).
// Revision : 1.0  initial release
// ============================================================================
module tb_irr_param;

    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] ir_in;
    logic [N_CH-1:0] trig_level;
    logic            init;
    logic            freeze;
    logic [N_CH-1:0] clear_irr;
    logic [N_CH-1:0] lost_clr;
    logic [N_CH-1:0] irr_out;
    logic            irr_any;
    logic [N_CH-1:0] lost_req;

    int n_tests = 0;
    int n_fail  = 0;

    irr_param #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir_in      (ir_in),
        .trig_level (trig_level),
        .init       (init),
        .freeze     (freeze),
        .clear_irr  (clear_irr),
        .lost_clr   (lost_clr),
        .irr_out    (irr_out),
        .irr_any    (irr_any),
        .lost_req   (lost_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ir_in      = '0;
        trig_level = '0;
        init       = 1'b0;
        freeze     = 1'b0;
        clear_irr  = '0;
        lost_clr   = '0;
        tick(3);
        check("reset_irr",  32'(irr_out),  32'h00);
        check("reset_any",  32'(irr_any),  32'h0);
        check("reset_lost", 32'(lost_req), 32'h00);
        rst_n = 1'b1;
        tick(2);

        // Edge capture with SYNC_STAGES+1 latency, then clear without re-trigger
        ir_in = 8'h08;
        tick(2);
        check("edge_lat_early", 32'(irr_out), 32'h00);
        tick(1);
        check("edge_lat_irr", 32'(irr_out), 32'h08);
        check("edge_lat_any", 32'(irr_any), 32'h1);
        clear_irr = 8'h08;
        tick(1);
        clear_irr = '0;
        check("edge_clear", 32'(irr_out), 32'h00);
        check("edge_clear_any", 32'(irr_any), 32'h0);
        tick(2);
        check("edge_no_retrig", 32'(irr_out), 32'h00);
        ir_in = '0;
        tick(3);

        // Level mode: cleared bit re-asserts, withdraw follows line after 3 cycles
        trig_level = 8'hFF;
        ir_in      = 8'h20;
        tick(3);
        check("level_set", 32'(irr_out), 32'h20);
        clear_irr = 8'h20;
        tick(1);
        clear_irr = '0;
        check("level_clear", 32'(irr_out), 32'h00);
        tick(1);
        check("level_reassert", 32'(irr_out), 32'h20);
        ir_in = '0;
        tick(2);
        check("level_drop_early", 32'(irr_out), 32'h20);
        tick(1);
        check("level_drop", 32'(irr_out), 32'h00);
        trig_level = '0;
        tick(2);

        // Freeze holds off an edge until release
        freeze = 1'b1;
        ir_in  = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("freeze_hold", 32'(irr_out), 32'h00);
        end
        freeze = 1'b0;
        tick(1);
        check("freeze_release", 32'(irr_out), 32'h02);
        tick(1);
        check("freeze_after", 32'(irr_out), 32'h02);
        clear_irr = 8'h02;
        tick(1);
        clear_irr = '0;
        ir_in     = '0;
        tick(3);

        // Held edge whose line drops before release is discarded
        freeze = 1'b1;
        ir_in  = 8'h02;
        tick(3);
        ir_in = '0;
        tick(2);
        check("freeze_drop_hold", 32'(irr_out), 32'h00);
        freeze = 1'b0;
        tick(1);
        check("freeze_drop_rel", 32'(irr_out), 32'h00);
        tick(1);

        // Clear still applies while frozen
        ir_in = 8'h06;
        tick(3);
        check("fclr_pre", 32'(irr_out), 32'h06);
        freeze    = 1'b1;
        clear_irr = 8'h02;
        tick(1);
        check("fclr_cleared", 32'(irr_out), 32'h04);
        freeze    = 1'b0;
        clear_irr = '0;
        tick(1);
        check("fclr_after", 32'(irr_out), 32'h04);
        clear_irr = 8'h04;
        tick(1);
        clear_irr = '0;
        ir_in     = '0;
        tick(3);

        // init re-arm: a line already high must fall and rise again
        ir_in = 8'h01;
        tick(3);
        check("init_pre", 32'(irr_out), 32'h01);
        init = 1'b1;
        tick(1);
        init = 1'b0;
        check("init_clear", 32'(irr_out), 32'h00);
        tick(3);
        check("init_stays", 32'(irr_out), 32'h00);
        ir_in = '0;
        tick(3);
        ir_in = 8'h01;
        tick(2);
        check("init_rearm_early", 32'(irr_out), 32'h00);
        tick(1);
        check("init_rearm", 32'(irr_out), 32'h01);
        clear_irr = 8'h01;
        tick(1);
        clear_irr = '0;
        ir_in     = '0;
        tick(3);

        // Rise coinciding with clear survives and is not an overrun
        ir_in = 8'h80;
        tick(2);
        clear_irr = 8'h80;
        tick(1);
        clear_irr = '0;
        check("simul_irr", 32'(irr_out), 32'h80);
        check("simul_lost", 32'(lost_req), 32'h00);

        // Overrun: outside freeze a withdrawn line drops irr, so the second
        // pulse must land while frozen to find irr[7] still pending.
        freeze = 1'b1;
        ir_in  = 8'h00;
        tick(1);
        ir_in = 8'h80;
        tick(3);
        check("ovr_lost", 32'(lost_req), 32'h80);
        check("ovr_irr", 32'(irr_out), 32'h80);
        freeze = 1'b0;
        tick(1);
        check("ovr_rel_irr", 32'(irr_out), 32'h80);
        check("ovr_rel_lost", 32'(lost_req), 32'h80);
        lost_clr = 8'h80;
        tick(1);
        lost_clr = '0;
        check("ovr_lost_clr", 32'(lost_req), 32'h00);

        // Asynchronous reset in the middle of a freeze window
        freeze = 1'b1;
        tick(1);
        rst_n = 1'b0;
        #1;
        check("async_rst_irr", 32'(irr_out), 32'h00);
        check("async_rst_any", 32'(irr_any), 32'h0);
        check("async_rst_lost", 32'(lost_req), 32'h00);
        freeze = 1'b0;
        ir_in  = '0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
